c17v2_bist_ctrl: RTL

Built-in self-test controller for the C17V2 combinational benchmark (5 inputs G1gat–G5gat, 2 outputs G6gat/G7gat). It sequences an exhaustive 32-vector test:
- drives each vector onto the circuit-under-test (CUT) inputs and waits a programmable settle time;
- captures and compacts the responses into per-output ones-counts;
- compares the counts to golden values and reports pass/fail.

It sits beside the C17V2 instance in the fault-injection test harness. It is the only driver of the CUT inputs while busy.

---
 rtl/c17v2_bist_pkg.sv | 24 ++
 rtl/c17v2_resp_cnt.sv | 43 ++++
 rtl/c17v2_bist_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/c17v2_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c17v2_bist_pkg
// Description : Shared types and sizing constants for the C17V2 BIST
//               controller: FSM state encoding, pattern/count/timer widths.
// Revision    : 1.0  initial release
// ============================================================================
package c17v2_bist_pkg;

    localparam int PAT_W        = 5;   // CUT input width (G1gat..G5gat)
    localparam int CNT_W        = 6;   // ones-count width, holds 0..32
    localparam int NUM_PATTERNS = 32;  // exhaustive vector count
    localparam int TMR_W        = 4;   // settle timer width, holds 0..15

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/c17v2_resp_cnt.sv
`default_nettype none
// ============================================================================
// Module      : c17v2_resp_cnt
// Description : Ones-counter compacting one CUT output over a test run.
//               clk   in  clock
//               rst   in  asynchronous active-high reset
//               clr   in  synchronous clear (wins over en)
//               en    in  capture strobe; adds resp when high
//               resp  in  CUT response bit
//               count out accumulated ones-count
// Revision    : 1.0  initial release
// ============================================================================
module c17v2_resp_cnt
    import c17v2_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             resp,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(NUM_PATTERNS);

    logic [CNT_W-1:0] r_count;

    // At most NUM_PATTERNS captures occur between clears, so the ceiling is
    // never reached in normal use; the guard just makes wrap impossible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && resp && (r_count != c_cnt_max)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/c17v2_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : c17v2_bist_ctrl
// Description : Exhaustive-vector BIST controller for the C17V2 benchmark.
//               Applies vectors 0..31, holds each SETTLE_CYCLES cycles,
//               counts ones on G6gat/G7gat and compares with golden counts.
//               clk    in  clock
//               rst    in  asynchronous active-high reset
//               start  in  begin a run (sampled in IDLE or DONE)
//               abort  in  cancel a run in progress
//               pat_o  out CUT stimulus, bit0 -> G1gat .. bit4 -> G5gat
//               g6_i   in  CUT G6gat response
//               g7_i   in  CUT G7gat response
//               busy   out run in progress
//               done   out result valid
//               pass   out both counts matched golden
//               cnt_g6 out G6gat ones-count
//               cnt_g7 out G7gat ones-count
// Revision    : 1.0  initial release
// ============================================================================
module c17v2_bist_ctrl
    import c17v2_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,   // legal range 1..15
    parameter int GOLD_G6       = 18,
    parameter int GOLD_G7       = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [PAT_W-1:0] pat_o,
    input  logic             g6_i,
    input  logic             g7_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] cnt_g6,
    output logic [CNT_W-1:0] cnt_g7
);

    localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [PAT_W-1:0] c_pat_last = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] c_gold_g6  = CNT_W'(GOLD_G6);
    localparam logic [CNT_W-1:0] c_gold_g7  = CNT_W'(GOLD_G7);

    state_t           r_state;
    state_t           w_next;
    logic [PAT_W-1:0] r_pat;
    logic [TMR_W-1:0] r_tmr;
    logic             r_pass;

    logic w_clear;      // start of a run or abort: wipe pattern/timer/counts/pass
    logic w_pat_inc;
    logic w_tmr_inc;
    logic w_tmr_clr;
    logic w_cnt_en;
    logic w_pass_set;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_clear    = 1'b0;
        w_pat_inc  = 1'b0;
        w_tmr_inc  = 1'b0;
        w_tmr_clr  = 1'b0;
        w_cnt_en   = 1'b0;
        w_pass_set = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next  = ST_SETTLE;
                    w_clear = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end else if (r_tmr == c_tmr_last) begin
                    w_next = ST_CAPTURE;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                    if (r_pat == c_pat_last) begin
                        w_next = ST_COMPARE;
                    end else begin
                        w_next    = ST_SETTLE;
                        w_pat_inc = 1'b1;
                        w_tmr_clr = 1'b1;
                    end
                end
            end
            ST_COMPARE: begin
                if (abort) begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end else begin
                    w_next     = ST_DONE;
                    w_pass_set = 1'b1;
                end
            end
            default: begin
                w_next  = ST_IDLE;
                w_clear = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pattern register, settle timer and pass flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= '0;
            r_tmr  <= '0;
            r_pass <= 1'b0;
        end else begin
            if (w_clear) begin
                r_pat <= '0;
            end else if (w_pat_inc) begin
                r_pat <= r_pat + PAT_W'(1);
            end

            if (w_clear || w_tmr_clr) begin
                r_tmr <= '0;
            end else if (w_tmr_inc) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end

            if (w_clear) begin
                r_pass <= 1'b0;
            end else if (w_pass_set) begin
                r_pass <= (cnt_g6 == c_gold_g6) && (cnt_g7 == c_gold_g7);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response compaction
    // ------------------------------------------------------------------
    c17v2_resp_cnt u_cnt_g6 (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clear),
        .en    (w_cnt_en),
        .resp  (g6_i),
        .count (cnt_g6)
    );

    c17v2_resp_cnt u_cnt_g7 (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clear),
        .en    (w_cnt_en),
        .resp  (g7_i),
        .count (cnt_g7)
    );

    assign pat_o = r_pat;
    assign busy  = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE) ||
                   (r_state == ST_COMPARE);
    assign done  = (r_state == ST_DONE);
    assign pass  = r_pass;

endmodule
`default_nettype wire
